// File: rtl/wb_dp_bram_pipe.sv
// Dual-port Wishbone B4 pipelined block RAM with byte-lane writes and read-first collisions.
// Define WB_DP_BRAM_REGOUT_EN to add an output register stage (2-cycle ack latency).
module wb_dp_bram_pipe #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic          o_a_stall,
    output logic          o_a_ack,
    output logic [DW-1:0] o_a_data,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic          o_b_stall,
    output logic          o_b_ack,
    output logic [DW-1:0] o_b_data
);

    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    logic          a_req;
    logic          b_req;
    logic          a_acc;
    logic          b_acc;
    logic          a_ack1;
    logic          b_ack1;
    logic [DW-1:0] a_rdata1;
    logic [DW-1:0] b_rdata1;
    logic          a_ack_out;
    logic          b_ack_out;
    logic [DW-1:0] a_data_out;
    logic [DW-1:0] b_data_out;

    assign a_req = i_a_cyc && i_a_stb;
    assign b_req = i_b_cyc && i_b_stb;

    // Only a same-address write/write collision holds B off; A always wins that cycle.
    assign o_a_stall = 1'b0;
    assign o_b_stall = !i_reset && a_req && i_a_we && b_req && i_b_we
                       && (i_a_addr == i_b_addr);

    assign a_acc = a_req && !i_reset;
    assign b_acc = b_req && !o_b_stall && !i_reset;

    always_ff @(posedge i_clk) begin
        if (a_acc && i_a_we) begin
            for (int n = 0; n < SW; n++) begin
                if (i_a_sel[n]) begin
                    mem[i_a_addr][n*8 +: 8] <= i_a_data[n*8 +: 8];
                end
            end
        end
        if (b_acc && i_b_we) begin
            for (int n = 0; n < SW; n++) begin
                if (i_b_sel[n]) begin
                    mem[i_b_addr][n*8 +: 8] <= i_b_data[n*8 +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_ack1   <= 1'b0;
            b_ack1   <= 1'b0;
            a_rdata1 <= '0;
            b_rdata1 <= '0;
        end else begin
            a_ack1 <= a_acc;
            b_ack1 <= b_acc;
            if (a_acc && !i_a_we) begin
                a_rdata1 <= mem[i_a_addr];
            end
            if (b_acc && !i_b_we) begin
                b_rdata1 <= mem[i_b_addr];
            end
        end
    end

`ifdef WB_DP_BRAM_REGOUT_EN
    logic          a_ack2;
    logic          b_ack2;
    logic [DW-1:0] a_rdata2;
    logic [DW-1:0] b_rdata2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_ack2   <= 1'b0;
            b_ack2   <= 1'b0;
            a_rdata2 <= '0;
            b_rdata2 <= '0;
        end else begin
            a_ack2   <= a_ack1 && i_a_cyc;
            b_ack2   <= b_ack1 && i_b_cyc;
            a_rdata2 <= a_rdata1;
            b_rdata2 <= b_rdata1;
        end
    end

    assign a_ack_out  = a_ack2;
    assign b_ack_out  = b_ack2;
    assign a_data_out = a_rdata2;
    assign b_data_out = b_rdata2;
`else
    assign a_ack_out  = a_ack1;
    assign b_ack_out  = b_ack1;
    assign a_data_out = a_rdata1;
    assign b_data_out = b_rdata1;
`endif

    // Acks vanish while cyc is low or reset is high, so nothing stale leaks out.
    assign o_a_ack  = a_ack_out && i_a_cyc && !i_reset;
    assign o_b_ack  = b_ack_out && i_b_cyc && !i_reset;
    assign o_a_data = i_reset ? '0 : a_data_out;
    assign o_b_data = i_reset ? '0 : b_data_out;

endmodule

// File: tb/tb_wb_dp_bram_pipe.sv
// Directed table-driven bench for wb_dp_bram_pipe (DW=32, AW=4).
module tb_wb_dp_bram_pipe;

    localparam int DW = 32;
    localparam int AW = 4;
`ifdef WB_DP_BRAM_REGOUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int IDL = 0;
    localparam int RD  = 1;
    localparam int WR  = 2;
    localparam int HLD = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [3:0]    a_sel, b_sel;
    logic          a_stall, a_ack, b_stall, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          ac;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic [3:0]  as;
        int          bc;
        logic [3:0]  ba;
        logic [31:0] bd;
        logic [3:0]  bs;
        logic        rst;
        logic        ea_ack;
        logic        ea_chk;
        logic [31:0] ea_data;
        logic        eb_ack;
        logic        eb_chk;
        logic [31:0] eb_data;
        logic        eb_stall;
    } vec_t;

    vec_t vecs[$];

    wb_dp_bram_pipe #(.DW(DW), .AW(AW)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
        .i_a_data(a_wdata), .i_a_sel(a_sel),
        .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_data(a_rdata),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
        .i_b_data(b_wdata), .i_b_sel(b_sel),
        .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_data(b_rdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input int ac, input logic [3:0] aa, input logic [31:0] ad,
                               input logic [3:0] as, input int bc, input logic [3:0] ba,
                               input logic [31:0] bd, input logic [3:0] bs, input logic rst,
                               input logic eaa, input logic eac, input logic [31:0] ead,
                               input logic eba, input logic ebc, input logic [31:0] ebd,
                               input logic ebs);
        vec_t t;
        t.ac = ac; t.aa = aa; t.ad = ad; t.as = as;
        t.bc = bc; t.ba = ba; t.bd = bd; t.bs = bs;
        t.rst = rst;
        t.ea_ack = eaa; t.ea_chk = eac; t.ea_data = ead;
        t.eb_ack = eba; t.eb_chk = ebc; t.eb_data = ebd;
        t.eb_stall = ebs;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        reset   = t.rst;
        a_cyc   = (t.ac != IDL);
        a_stb   = (t.ac == RD) || (t.ac == WR);
        a_we    = (t.ac == WR);
        a_addr  = t.aa;
        a_wdata = t.ad;
        a_sel   = t.as;
        b_cyc   = (t.bc != IDL);
        b_stb   = (t.bc == RD) || (t.bc == WR);
        b_we    = (t.bc == WR);
        b_addr  = t.ba;
        b_wdata = t.bd;
        b_sel   = t.bs;
        #1;
    endtask

    task automatic checkOutput(input vec_t t, input string tag);
        check({tag, " a_ack"}, {31'b0, a_ack}, {31'b0, t.ea_ack});
        check({tag, " b_ack"}, {31'b0, b_ack}, {31'b0, t.eb_ack});
        check({tag, " b_stall"}, {31'b0, b_stall}, {31'b0, t.eb_stall});
        check({tag, " a_stall"}, {31'b0, a_stall}, 32'b0);
        if (t.ea_chk) check({tag, " a_data"}, a_rdata, t.ea_data);
        if (t.eb_chk) check({tag, " b_data"}, b_rdata, t.eb_data);
    endtask

    function automatic logic [31:0] burst_val(input int i);
        return 32'hC0DE_0000 | 32'(i * 'h111);
    endfunction

    initial begin
        reset = 1'b1;
        a_cyc = 0; a_stb = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_sel = 0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_sel = 0;

        // Reset state: everything quiet and zero, colliding writes neither stall nor commit.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(v(IDL,0,0,0, IDL,0,0,0, 1, 0,1,0, 0,1,0, 0));
            checkOutput(v(IDL,0,0,0, IDL,0,0,0, 1, 0,1,0, 0,1,0, 0), $sformatf("reset%0d", i));
        end

`ifndef WB_DP_BRAM_REGOUT_EN
        vecs.push_back(v(WR,7,32'h99,4'hF, WR,7,32'h98,4'hF, 1, 0,1,0, 0,1,0, 0));
        vecs.push_back(v(RD,3,0,0, RD,3,0,0, 1, 0,1,0, 0,1,0, 0));
        vecs.push_back(v(IDL,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(WR,3,32'hDEADBEEF,4'hF, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(HLD,0,0,0, RD,3,0,0, 0, 1,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, HLD,0,0,0, 0, 0,0,0, 1,1,32'hDEADBEEF, 0));
        vecs.push_back(v(WR,5,32'h11223344,4'hF, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(WR,5,32'hAABBCCDD,4'h5, IDL,0,0,0, 0, 1,0,0, 0,0,0, 0));
        vecs.push_back(v(RD,5,0,0, IDL,0,0,0, 0, 1,0,0, 0,0,0, 0));
        vecs.push_back(v(HLD,0,0,0, IDL,0,0,0, 0, 1,1,32'h11BB33DD, 0,0,0, 0));
        vecs.push_back(v(WR,7,32'h1,4'hF, WR,7,32'h2,4'hF, 0, 0,0,0, 0,0,0, 1));
        vecs.push_back(v(HLD,0,0,0, WR,7,32'h2,4'hF, 0, 1,0,0, 0,0,0, 0));
        vecs.push_back(v(RD,7,0,0, HLD,0,0,0, 0, 0,0,0, 1,0,0, 0));
        vecs.push_back(v(HLD,0,0,0, IDL,0,0,0, 0, 1,1,32'h2, 0,0,0, 0));
        vecs.push_back(v(WR,9,32'h55,4'hF, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(WR,9,32'h66,4'hF, RD,9,0,0, 0, 1,0,0, 0,0,0, 0));
        vecs.push_back(v(RD,9,0,0, HLD,0,0,0, 0, 1,0,0, 1,1,32'h55, 0));
        vecs.push_back(v(HLD,0,0,0, IDL,0,0,0, 0, 1,1,32'h66, 0,0,0, 0));
        vecs.push_back(v(RD,3,0,0, RD,3,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(HLD,0,0,0, HLD,0,0,0, 0, 1,1,32'hDEADBEEF, 1,1,32'hDEADBEEF, 0));
        vecs.push_back(v(IDL,0,0,0, RD,5,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, RD,7,0,0, 0, 0,0,0, 1,1,32'h11BB33DD, 0));
        vecs.push_back(v(IDL,0,0,0, RD,9,0,0, 0, 0,0,0, 1,1,32'h2, 0));
        vecs.push_back(v(IDL,0,0,0, HLD,0,0,0, 0, 0,0,0, 1,1,32'h66, 0));
        vecs.push_back(v(RD,3,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(HLD,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, WR,12,32'h12345678,4'hF, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, RD,12,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, HLD,0,0,0, 0, 0,0,0, 1,1,32'h12345678, 0));
        vecs.push_back(v(RD,3,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(RD,5,0,0, IDL,0,0,0, 0, 1,1,32'hDEADBEEF, 0,0,0, 0));
        vecs.push_back(v(RD,7,0,0, IDL,0,0,0, 1, 0,1,0, 0,1,0, 0));
        vecs.push_back(v(HLD,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(HLD,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
        vecs.push_back(v(IDL,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("row%0d", i));
        end
`else
        applyStimulus(v(IDL,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));
`endif

        // Back-to-back write burst then read burst on A: acks contiguous, LAT cycles late.
        for (int c = 0; c < 8 + LAT + 1; c++) begin
            vec_t t;
            logic exp_ack;
            exp_ack = (c >= LAT) && (c < 8 + LAT);
            if (c < 8)
                t = v(WR,4'(c),burst_val(c),4'hF, IDL,0,0,0, 0, exp_ack,0,0, 0,0,0, 0);
            else
                t = v(HLD,0,0,0, IDL,0,0,0, 0, exp_ack,0,0, 0,0,0, 0);
            applyStimulus(t);
            checkOutput(t, $sformatf("wburst%0d", c));
        end
        for (int c = 0; c < 8 + LAT + 1; c++) begin
            vec_t t;
            logic exp_ack;
            logic [31:0] exp_data;
            exp_ack  = (c >= LAT) && (c < 8 + LAT);
            exp_data = exp_ack ? burst_val(c - LAT) : 32'h0;
            if (c < 8)
                t = v(RD,4'(c),0,0, IDL,0,0,0, 0, exp_ack,exp_ack,exp_data, 0,0,0, 0);
            else
                t = v(HLD,0,0,0, IDL,0,0,0, 0, exp_ack,exp_ack,exp_data, 0,0,0, 0);
            applyStimulus(t);
            checkOutput(t, $sformatf("rburst%0d", c));
        end
        applyStimulus(v(IDL,0,0,0, IDL,0,0,0, 0, 0,0,0, 0,0,0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
